psum_drain: RTL and testbench

Downstream drain stage for the three-lane add cell. It accumulates a programmable number of consecutive 32-bit partial-sum vectors (lanes 0..2) and buffers each completed result triple in a small FIFO. It then serializes the triples lane by lane onto a single 32-bit valid/ready stream toward the result writer.

---
 rtl/psum_drain.sv | 234 +++++++++++++++++++++++
 tb/tb_psum_drain.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/psum_drain.sv
// -----------------------------------------------------------------------------
// psum_drain
//
// Drain stage behind the three-lane add cell. It sums a programmable number of
// consecutive partial-sum vectors per lane, buffers each finished triple in a
// small FIFO, and sends the buffered triples out one lane at a time on a
// single 32-bit stream.
//
// Parameters
//   DEPTH      FIFO capacity in result triples (power of two, >= 2)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   psum_in_0  lane 0 partial sum
//   psum_in_1  lane 1 partial sum
//   psum_in_2  lane 2 partial sum
//   psum_vld   all three lanes valid this cycle (no backpressure upstream)
//   acc_len    vectors per group, sampled at group start; 0 means 16
//   clr        synchronous abort of the group in progress (FIFO untouched)
//   out_data   serialized result word
//   out_lane   lane index of out_data
//   out_last   high on the lane 2 beat
//   out_valid  out_data valid
//   out_ready  sink accepts the beat
//   fifo_cnt   triples currently buffered
//   ovf        sticky: a finished triple was dropped; cleared only by reset
//
// Output handshake: a beat transfers on a rising edge where out_valid and
// out_ready are both high. Once out_valid is raised, out_data, out_lane and
// out_last hold constant until that transfer happens; out_valid only falls
// after a transfer (or on reset). out_ready may change freely.
// -----------------------------------------------------------------------------
module psum_drain #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [31:0]                psum_in_0,
    input  logic [31:0]                psum_in_1,
    input  logic [31:0]                psum_in_2,
    input  logic                       psum_vld,
    input  logic [3:0]                 acc_len,
    input  logic                       clr,
    output logic [31:0]                out_data,
    output logic [1:0]                 out_lane,
    output logic                       out_last,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] fifo_cnt,
    output logic                       ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    // ------------------------------------------------------------------
    // Accumulator
    // ------------------------------------------------------------------
    logic [3:0]        cnt;
    logic [4:0]        len_q;
    logic [2:0][31:0]  acc;
    logic [2:0][31:0]  psum;
    logic [2:0][31:0]  sum;
    logic [4:0]        len_eff;
    logic [4:0]        cur_len;
    logic              take;
    logic              done;

    assign psum = {psum_in_2, psum_in_1, psum_in_0};

    always_comb begin
        len_eff = (acc_len == 4'd0) ? 5'd16 : {1'b0, acc_len};
        // The first vector of a group decides the group length.
        cur_len = (cnt == 4'd0) ? len_eff : len_q;
        take    = psum_vld && !clr;
        done    = take && (({1'b0, cnt} + 5'd1) == cur_len);
        for (int i = 0; i < 3; i++) begin
            sum[i] = (cnt == 4'd0) ? psum[i] : acc[i] + psum[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= 4'd0;
            len_q <= 5'd1;
            acc   <= '0;
        end else if (clr) begin
            cnt <= 4'd0;
        end else if (psum_vld) begin
            if (cnt == 4'd0) begin
                len_q <= len_eff;
            end
            // The finished sum goes straight to the FIFO; acc is left stale
            // because the next group reloads it from its first vector.
            if (done) begin
                cnt <= 4'd0;
            end else begin
                cnt <= cnt + 4'd1;
                acc <= sum;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LANE0 = 2'd1,
        LANE1 = 2'd2,
        LANE2 = 2'd3
    } state_t;

    state_t            state;
    logic [2:0][31:0]  mem [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              full;
    logic              pop;
    logic              push_ok;
    logic              drop;

    always_comb begin
        pop  = (state == LANE2) && out_ready;
        full = (count == CW'(DEPTH));
        // A pop on the same edge frees the slot, so a full FIFO still accepts.
        push_ok = done && (!full || pop);
        drop    = done && full && !pop;
        case ({push_ok, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count_nxt;
            if (drop) begin
                ovf <= 1'b1;
            end
        end
    end

    assign fifo_cnt = count;

    // ------------------------------------------------------------------
    // Serializer FSM (state and beat qualifiers registered together)
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_lane  <= 2'd0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (count != '0) begin
                        state     <= LANE0;
                        out_valid <= 1'b1;
                        out_lane  <= 2'd0;
                        out_last  <= 1'b0;
                    end
                end
                LANE0: begin
                    if (out_ready) begin
                        state    <= LANE1;
                        out_lane <= 2'd1;
                    end
                end
                LANE1: begin
                    if (out_ready) begin
                        state    <= LANE2;
                        out_lane <= 2'd2;
                        out_last <= 1'b1;
                    end
                end
                LANE2: begin
                    if (out_ready) begin
                        out_lane <= 2'd0;
                        out_last <= 1'b0;
                        // Chain straight into the next triple when one is left.
                        if (count_nxt != '0) begin
                            state <= LANE0;
                        end else begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_lane  <= 2'd0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

    // The head entry cannot change while a triple is being sent: pops only
    // happen on the lane 2 transfer, and a write into the head slot (full
    // FIFO) is only accepted on that same edge.
    always_comb begin
        case (state)
            LANE0:   out_data = mem[rd_ptr][0];
            LANE1:   out_data = mem[rd_ptr][1];
            LANE2:   out_data = mem[rd_ptr][2];
            default: out_data = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_psum_drain.sv
// -----------------------------------------------------------------------------
// tb_psum_drain
//
// Bench for psum_drain. A transaction-level model keeps the current group as a
// list of vectors, the FIFO as a queue of triples and the serializer as a
// beat position; a compare process checks every DUT output against it each
// cycle. Directed scenarios pin the model with hand-computed values, and a
// randomized phase follows.
// -----------------------------------------------------------------------------
module tb_psum_drain;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH+1);

  // clock / reset / DUT signals
  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   psum_in_0, psum_in_1, psum_in_2;
  logic          psum_vld;
  logic [3:0]    acc_len;
  logic          clr;
  logic [31:0]   out_data;
  logic [1:0]    out_lane;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] fifo_cnt;
  logic          ovf;

  always #5 clk = ~clk;

  psum_drain #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .psum_in_0 (psum_in_0),
    .psum_in_1 (psum_in_1),
    .psum_in_2 (psum_in_2),
    .psum_vld  (psum_vld),
    .acc_len   (acc_len),
    .clr       (clr),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .fifo_cnt  (fifo_cnt),
    .ovf       (ovf)
  );

  // counters
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model
  // ---------------------------------------------------------------------------
  logic [95:0] grp[$];        // vectors of the group in progress
  int          m_target = 0;  // length of the group in progress
  logic [95:0] m_q[$];        // buffered triples, lane k at [32k +: 32]
  int          m_beat = -1;   // -1: nothing on the bus, else lane being shown
  logic        m_ovf = 1'b0;
  logic [31:0] exp_q[$];      // beats expected on the stream, in order

  int          old_size;
  logic        m_hs;
  logic [31:0] s;
  logic [95:0] trip;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        grp.delete();
        m_q.delete();
        exp_q.delete();
        m_target = 0;
        m_beat   = -1;
        m_ovf    = 1'b0;
      end else if (clk) begin
        cyc++;
        old_size = m_q.size();
        m_hs     = (m_beat >= 0) && out_ready;
        if (m_hs && m_beat == 2) void'(m_q.pop_front());
        if (clr) begin
          grp.delete();
        end else if (psum_vld) begin
          if (grp.size() == 0) m_target = (acc_len == 4'd0) ? 16 : int'(acc_len);
          grp.push_back({psum_in_2, psum_in_1, psum_in_0});
          if (grp.size() == m_target) begin
            for (int k = 0; k < 3; k++) begin
              s = 32'd0;
              foreach (grp[j]) s = s + grp[j][32*k +: 32];
              trip[32*k +: 32] = s;
            end
            grp.delete();
            if (m_q.size() < DEPTH) begin
              m_q.push_back(trip);
              for (int k = 0; k < 3; k++) exp_q.push_back(trip[32*k +: 32]);
            end else begin
              m_ovf = 1'b1;
            end
          end
        end
        if (m_beat < 0) begin
          if (old_size > 0) m_beat = 0;
        end else if (m_hs) begin
          if (m_beat < 2) m_beat = m_beat + 1;
          else m_beat = (m_q.size() > 0) ? 0 : -1;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Compare process and beat log (sampled on the falling edge)
  // ---------------------------------------------------------------------------
  logic [31:0] log_d[$];
  logic [1:0]  log_l[$];
  logic        log_last[$];
  int          log_c[$];

  logic        e_valid;
  logic [31:0] e_data;
  logic        p_valid = 1'b0, p_ready = 1'b0, p_rst = 1'b0, p_last = 1'b0;
  logic [31:0] p_data = 32'd0;
  logic [1:0]  p_lane = 2'd0;
  logic [31:0] sb_word;

  initial begin
    forever begin
      @(negedge clk);
      e_valid = (m_beat >= 0);
      e_data  = e_valid ? m_q[0][32*m_beat +: 32] : 32'd0;
      check("out_valid", 32'(out_valid), 32'(e_valid));
      check("out_data", out_data, e_data);
      check("out_lane", 32'(out_lane), e_valid ? 32'(m_beat) : 32'd0);
      check("out_last", 32'(out_last), 32'(m_beat == 2));
      check("fifo_cnt", 32'(fifo_cnt), 32'(m_q.size()));
      check("ovf", 32'(ovf), 32'(m_ovf));
      if (p_rst && rst_n && p_valid && !p_ready) begin
        check("hold_data", out_data, p_data);
        check("hold_lane", 32'(out_lane), 32'(p_lane));
        check("hold_last", 32'(out_last), 32'(p_last));
      end
      if (out_valid && out_ready) begin
        log_d.push_back(out_data);
        log_l.push_back(out_lane);
        log_last.push_back(out_last);
        log_c.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          sb_word = exp_q.pop_front();
          check("sb_beat", out_data, sb_word);
        end
      end
      p_valid = out_valid;
      p_ready = out_ready;
      p_rst   = rst_n;
      p_data  = out_data;
      p_lane  = out_lane;
      p_last  = out_last;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                      input logic [3:0] len, input logic do_clr);
    psum_in_0 = a;
    psum_in_1 = b;
    psum_in_2 = c;
    acc_len   = len;
    psum_vld  = 1'b1;
    clr       = do_clr;
    step();
    psum_vld  = 1'b0;
    clr       = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    out_ready = 1'b1;
    while ((m_q.size() != 0 || m_beat >= 0) && n < budget) begin
      step();
      n++;
    end
    check("drain_in_time", 32'(n < budget), 32'd1);
    step();
  endtask

  task automatic clear_log();
    log_d.delete();
    log_l.delete();
    log_last.delete();
    log_c.delete();
  endtask

  task automatic check_beat(input string name, input int idx, input logic [31:0] d,
                            input logic [1:0] l, input logic la);
    if (idx >= log_d.size()) begin
      check({name, "_missing"}, 32'(log_d.size()), 32'(idx + 1));
    end else begin
      check({name, "_data"}, log_d[idx], d);
      check({name, "_lane"}, 32'(log_l[idx]), 32'(l));
      check({name, "_last"}, 32'(log_last[idx]), 32'(la));
    end
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "time limit");
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int n;
    rst_n = 1'b0;
    psum_in_0 = '0; psum_in_1 = '0; psum_in_2 = '0;
    psum_vld = 1'b0; acc_len = 4'd0; clr = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", out_data, 32'd0);
    check("rst_lane", 32'(out_lane), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_cnt", 32'(fifo_cnt), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    rst_n = 1'b1;
    step();

    // basic accumulate and latency
    out_ready = 1'b1;
    clear_log();
    send(1, 2, 3, 4'd3, 1'b0);
    send(10, 20, 30, 4'd3, 1'b0);
    send(100, 200, 300, 4'd3, 1'b0);
    check("lat_cnt", 32'(fifo_cnt), 32'd1);
    check("lat_v_edge1", 32'(out_valid), 32'd0);
    step();
    check("lat_v_edge2", 32'(out_valid), 32'd1);
    check("lat_data", out_data, 32'd111);
    drain(50);
    check_beat("basic0", 0, 32'd111, 2'd0, 1'b0);
    check_beat("basic1", 1, 32'd222, 2'd1, 1'b0);
    check_beat("basic2", 2, 32'd333, 2'd2, 1'b1);

    // overflow
    clear_log();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) send(32'(k), 32'(k), 32'(k), 4'd1, 1'b0);
    check("ovf_cnt", 32'(fifo_cnt), 32'd4);
    check("ovf_flag", 32'(ovf), 32'd1);
    drain(100);
    check("ovf_beats", 32'(log_d.size()), 32'd12);
    for (int i = 0; i < 12; i++)
      check_beat("ovf_beat", i, 32'(i / 3 + 1), 2'(i % 3), (i % 3) == 2);
    if (log_c.size() == 12) check("ovf_no_bubble", 32'(log_c[11] - log_c[0]), 32'd11);
    check("ovf_cnt_end", 32'(fifo_cnt), 32'd0);
    check("ovf_sticky", 32'(ovf), 32'd1);

    // wrap-around
    clear_log();
    send(32'hFFFF_FFFF, 5, 6, 4'd2, 1'b0);
    send(32'h0000_0002, 7, 8, 4'd2, 1'b0);
    drain(50);
    check_beat("wrap0", 0, 32'h0000_0001, 2'd0, 1'b0);
    check_beat("wrap1", 1, 32'd12, 2'd1, 1'b0);
    check_beat("wrap2", 2, 32'd14, 2'd2, 1'b1);

    // backpressure
    clear_log();
    out_ready = 1'b0;
    send(5, 6, 7, 4'd1, 1'b0);
    for (int i = 0; i < 16; i++) begin
      out_ready = ~out_ready;
      step();
    end
    drain(50);
    check("bp_beats", 32'(log_d.size()), 32'd3);
    check_beat("bp0", 0, 32'd5, 2'd0, 1'b0);
    check_beat("bp1", 1, 32'd6, 2'd1, 1'b0);
    check_beat("bp2", 2, 32'd7, 2'd2, 1'b1);

    // clr mid-group
    clear_log();
    send(1000, 1000, 1000, 4'd4, 1'b0);
    send(1000, 1000, 1000, 4'd4, 1'b0);
    send(9, 9, 9, 4'd4, 1'b1);
    for (int i = 1; i <= 4; i++) send(32'(i), 32'(i), 32'(i), 4'd4, 1'b0);
    drain(50);
    check("clr_beats", 32'(log_d.size()), 32'd3);
    for (int i = 0; i < 3; i++) check_beat("clr", i, 32'd10, 2'(i), i == 2);

    // length 16
    clear_log();
    for (int i = 0; i < 16; i++) send(1, 1, 1, 4'd0, 1'b0);
    drain(50);
    for (int i = 0; i < 3; i++) check_beat("len16", i, 32'd16, 2'(i), i == 2);

    // reset during LANE1
    for (int i = 0; i < 16; i++) send(1, 1, 1, 4'd0, 1'b0);
    n = 0;
    while (!(out_valid && out_lane == 2'd1) && n < 20) begin
      step();
      n++;
    end
    check("reach_lane1", 32'(n < 20), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_cnt", 32'(fifo_cnt), 32'd0);
    check("mid_rst_data", out_data, 32'd0);
    clear_log();
    repeat (3) step();
    rst_n = 1'b1;
    repeat (10) step();
    check("post_rst_beats", 32'(log_d.size()), 32'd0);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      psum_in_0 = $urandom;
      psum_in_1 = $urandom;
      psum_in_2 = $urandom;
      psum_vld  = 1'($urandom_range(0, 1));
      clr       = ($urandom_range(0, 15) == 0);
      acc_len   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 3));
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    psum_vld = 1'b0;
    clr      = 1'b0;
    drain(200);
    check("rand_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
